// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-MM burst copy engine.
// The copy FSM alternates one read burst with one write burst through a small buffer.
package avalon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    DONE
  } copy_state_t;

  localparam int DEFAULT_BURSTCOUNT_W = 4;
  localparam int MAX_BURST            = 2 ** (DEFAULT_BURSTCOUNT_W - 1);

  function automatic int unsigned min_burst(input int unsigned remaining,
                                            input int unsigned max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/burst_buffer.sv
// Word buffer holding one burst between its read and write phases.
// Synchronous write port, asynchronous read port; contents are not reset.
module burst_buffer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/avalon_burst_copy.sv
// Avalon-MM host that copies a block of words from src_addr to dst_addr,
// moving up to MAX_BURST words per read burst followed by a matching write burst.
module avalon_burst_copy
  import avalon_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int BURSTCOUNT_W = 4,
  parameter int LEN_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       src_addr,
  input  logic [ADDR_W-1:0]       dst_addr,
  input  logic [LEN_W-1:0]        length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       address,
  output logic                    read,
  output logic                    write,
  output logic [BURSTCOUNT_W-1:0] burstcount,
  output logic [3:0]              byteenable,
  output logic [31:0]             writedata,
  input  logic [31:0]             readdata,
  input  logic                    readdatavalid,
  input  logic                    waitrequest
);

  localparam int BURST_MAX = 2 ** (BURSTCOUNT_W - 1);
  localparam int IDX_W     = (BURSTCOUNT_W > 1) ? BURSTCOUNT_W - 1 : 1;

  copy_state_t             state_reg, state_next;
  logic [ADDR_W-1:0]       src_reg, src_next;
  logic [ADDR_W-1:0]       dst_reg, dst_next;
  logic [LEN_W-1:0]        remaining_reg, remaining_next;
  logic [BURSTCOUNT_W-1:0] burst_reg, burst_next;
  logic [IDX_W-1:0]        rd_idx_reg, rd_idx_next;
  logic [IDX_W-1:0]        wr_idx_reg, wr_idx_next;
  logic                    buf_we;
  logic [31:0]             buf_rdata;
  logic [ADDR_W-1:0]       burst_bytes;

  function automatic logic [BURSTCOUNT_W-1:0] burst_of(input logic [LEN_W-1:0] rem);
    int unsigned b;
    b = min_burst(32'(rem), BURST_MAX);
    return b[BURSTCOUNT_W-1:0];
  endfunction

  burst_buffer #(
    .DEPTH (BURST_MAX),
    .IDX_W (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (rd_idx_reg),
    .wr_data (readdata),
    .rd_idx  (wr_idx_reg),
    .rd_data (buf_rdata)
  );

  assign burst_bytes = ADDR_W'({burst_reg, 2'b00});
  assign byteenable  = 4'hF;
  // The buffer is undefined outside a write burst, so the bus sees zero there.
  assign writedata   = (state_reg == WR_BURST) ? buf_rdata : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      burst_reg     <= BURSTCOUNT_W'(1);
      rd_idx_reg    <= '0;
      wr_idx_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      remaining_reg <= remaining_next;
      burst_reg     <= burst_next;
      rd_idx_reg    <= rd_idx_next;
      wr_idx_reg    <= wr_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    remaining_next = remaining_reg;
    burst_next     = burst_reg;
    rd_idx_next    = rd_idx_reg;
    wr_idx_next    = wr_idx_reg;
    buf_we         = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    read           = 1'b0;
    write          = 1'b0;
    address        = '0;
    burstcount     = BURSTCOUNT_W'(1);

    case (state_reg)
      IDLE: begin
        if (start) begin
          src_next       = src_addr & ~ADDR_W'(3);
          dst_next       = dst_addr & ~ADDR_W'(3);
          remaining_next = length;
          burst_next     = burst_of(length);
          state_next     = (length == '0) ? DONE : RD_REQ;
        end
      end

      RD_REQ: begin
        busy       = 1'b1;
        read       = 1'b1;
        address    = src_reg;
        burstcount = burst_reg;
        if (!waitrequest) begin
          rd_idx_next = '0;
          state_next  = RD_DATA;
        end
      end

      RD_DATA: begin
        busy = 1'b1;
        if (readdatavalid) begin
          buf_we      = 1'b1;
          rd_idx_next = rd_idx_reg + 1'b1;
          if (BURSTCOUNT_W'(rd_idx_reg) == burst_reg - 1'b1) begin
            wr_idx_next = '0;
            state_next  = WR_BURST;
          end
        end
      end

      WR_BURST: begin
        busy       = 1'b1;
        write      = 1'b1;
        address    = dst_reg;
        burstcount = burst_reg;
        if (!waitrequest) begin
          wr_idx_next = wr_idx_reg + 1'b1;
          if (BURSTCOUNT_W'(wr_idx_reg) == burst_reg - 1'b1) begin
            // Both pointers advance by the burst just moved; the next burst size is fixed here.
            src_next       = src_reg + burst_bytes;
            dst_next       = dst_reg + burst_bytes;
            remaining_next = remaining_reg - LEN_W'(burst_reg);
            burst_next     = burst_of(remaining_next);
            state_next     = (remaining_next == '0) ? DONE : RD_REQ;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_burst_copy.sv
// Bench for avalon_burst_copy: a latency/stall-capable memory agent plus a
// word-level copy model and expected burst list derived from length and addresses.
module tb_avalon_burst_copy;

  localparam int ADDR_W    = 32;
  localparam int BC_W      = 4;
  localparam int LEN_W     = 16;
  localparam int MAXB      = 8;
  localparam int LAT       = 2;
  localparam int MEM_WORDS = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BC_W-1:0]   burstcount;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              waitrequest;

  always #5 clk = ~clk;

  avalon_burst_copy #(
    .ADDR_W       (ADDR_W),
    .BURSTCOUNT_W (BC_W),
    .LEN_W        (LEN_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .address       (address),
    .read          (read),
    .write         (write),
    .burstcount    (burstcount),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    int          cnt;
  } burst_t;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  burst_t      obs_q[$];
  burst_t      exp_q[$];
  logic [31:0] rd_q[$];
  int          rd_delay = 0;
  int          wr_beat = 0;
  logic [31:0] wr_base = '0;
  int          wr_accepts = 0;
  int          done_cnt = 0;
  int          bus_cnt = 0;
  bit          wait_en = 0;
  bit          prev_rd_stall = 0;
  bit          prev_wr_stall = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic [3:0]  prev_bc = '0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Memory agent and protocol monitor: decides this cycle's bus response on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      rd_q.delete();
      rd_delay      = 0;
      wr_beat       = 0;
      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
      prev_rd_stall = 0;
      prev_wr_stall = 0;
    end else begin
      burst_t b;
      if (done) done_cnt++;
      if (read || write) bus_cnt++;
      check("rw_exclusive", read && write, 0);
      if (read) check("rd_while_outstanding", rd_q.size(), 0);
      if (prev_rd_stall) begin
        check("rd_hold_read", read, 1);
        check("rd_hold_addr", address, prev_addr);
        check("rd_hold_bc", burstcount, prev_bc);
      end
      if (prev_wr_stall) begin
        check("wr_hold_write", write, 1);
        check("wr_hold_addr", address, prev_addr);
        check("wr_hold_bc", burstcount, prev_bc);
        check("wr_hold_data", writedata, prev_wdata);
      end

      readdatavalid = 1'b0;
      readdata      = $urandom;
      if (rd_delay > 0) rd_delay--;
      else if (rd_q.size() > 0) begin
        readdatavalid = 1'b1;
        readdata      = mem[widx(rd_q.pop_front())];
      end

      waitrequest = wait_en ? ($urandom_range(0, 1) == 1) : 1'b0;

      if (read && !waitrequest) begin
        b.is_wr = 0; b.addr = address; b.cnt = int'(burstcount);
        obs_q.push_back(b);
        for (int i = 0; i < int'(burstcount); i++) rd_q.push_back(address + 32'(4 * i));
        rd_delay = LAT;
      end
      if (write && !waitrequest) begin
        check("byteenable", byteenable, 4'hF);
        if (wr_beat == 0) begin
          wr_base = address;
          b.is_wr = 1; b.addr = address; b.cnt = int'(burstcount);
          obs_q.push_back(b);
        end else begin
          check("wr_addr_const", address, wr_base);
        end
        mem[(widx(address) + wr_beat) % MEM_WORDS] = writedata;
        wr_beat++;
        wr_accepts++;
        if (wr_beat >= int'(burstcount)) wr_beat = 0;
      end

      prev_rd_stall = read && waitrequest;
      prev_wr_stall = write && waitrequest;
      prev_addr     = address;
      prev_bc       = burstcount;
      prev_wdata    = writedata;
    end
  end

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int len);
    src_addr = s;
    dst_addr = d;
    length   = LEN_W'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                          input bit we, input bit stray);
    int rem, bsz, d0, bus0;
    logic [31:0] sa, da;
    bit got;
    burst_t e;
    wait_en = we;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++)
      ref_mem[(widx(d) + i) % MEM_WORDS] = ref_mem[(widx(s) + i) % MEM_WORDS];
    rem = len;
    sa  = s & ~32'd3;
    da  = d & ~32'd3;
    while (rem > 0) begin
      bsz = (rem < MAXB) ? rem : MAXB;
      e.is_wr = 0; e.addr = sa; e.cnt = bsz; exp_q.push_back(e);
      e.is_wr = 1; e.addr = da; e.cnt = bsz; exp_q.push_back(e);
      sa  += 32'(4 * bsz);
      da  += 32'(4 * bsz);
      rem -= bsz;
    end
    d0   = done_cnt;
    bus0 = bus_cnt;
    @(negedge clk);
    pulse_start(s, d, len);
    if (len == 0) check("zero_len_done_next_cycle", done, 1);
    else check("busy_after_start", busy, 1);
    got = done;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      if (stray && cyc == 5) begin
        src_addr = 32'h0; dst_addr = 32'hC00; length = 16'd4; start = 1'b1;
      end
      if (stray && cyc == 6) start = 1'b0;
      @(negedge clk);
      #1;
      got = done;
    end
    check("done_seen", got, 1);
    check("busy_low_at_done", busy, 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt - d0, 1);
    if (len == 0) check("zero_len_no_bus", bus_cnt - bus0, 0);
    check("burst_list_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("burst_kind", obs_q[i].is_wr, exp_q[i].is_wr);
      check("burst_addr", obs_q[i].addr, exp_q[i].addr);
      check("burst_count", obs_q[i].cnt, exp_q[i].cnt);
    end
    for (int i = 0; i < len; i++)
      check("copy_data", mem[(widx(d) + i) % MEM_WORDS], ref_mem[(widx(d) + i) % MEM_WORDS]);
    $display("copy src=%0h dst=%0h len=%0d wait=%0d bursts=%0d", s, d, len, we, obs_q.size());
  endtask

  initial begin
    int w0, d0;
    reset         = 1'b1;
    start         = 1'b0;
    src_addr      = '0;
    dst_addr      = '0;
    length        = '0;
    readdata      = '0;
    readdatavalid = 1'b0;
    waitrequest   = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4]     = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_address", address, 0);
    check("rst_burstcount", burstcount, 1);
    check("rst_writedata", writedata, 0);
    check("rst_byteenable", byteenable, 4'hF);
    @(negedge clk);
    #1 reset = 1'b0;

    run_copy(32'h10, 32'h40, 1, 0, 0);
    check("deadbeef_copied", mem[widx(32'h40)], 32'hDEADBEEF);
    run_copy(32'h00, 32'h100, 8, 0, 0);
    run_copy(32'h20, 32'h300, 11, 0, 0);
    run_copy(32'h44, 32'h900, 11, 1, 0);
    run_copy(32'h30, 32'h800, 0, 0, 0);

    // Abort while the fourth write beat of an 8-word burst is on the bus.
    wait_en = 0;
    d0 = done_cnt;
    w0 = wr_accepts;
    @(negedge clk);
    pulse_start(32'h80, 32'h500, 8);
    for (int cyc = 0; cyc < 200 && (wr_accepts - w0) < 4; cyc++) begin
      @(negedge clk);
      #2;
    end
    check("abort_at_beat4", wr_accepts - w0, 4);
    check("abort_write_before", write, 1);
    reset = 1'b1;
    #1;
    check("abort_write", write, 0);
    check("abort_read", read, 0);
    check("abort_busy", busy, 0);
    check("abort_address", address, 0);
    check("abort_burstcount", burstcount, 1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem[i];
    run_copy(32'h200, 32'h600, 2, 0, 0);

    // Start pulsed mid-copy must be ignored and leave its destination untouched.
    run_copy(32'h100, 32'hA00, 10, 0, 1);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    #1;
    check("stray_no_extra_done", done_cnt - d0, 0);
    check("stray_idle", busy, 0);
    for (int i = 0; i < 4; i++)
      check("stray_dst_untouched", mem[widx(32'hC00) + i], ref_mem[widx(32'hC00) + i]);

    for (int n = 0; n < 4; n++) begin
      logic [31:0] s, d;
      int len;
      s   = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
      d   = 32'($urandom_range(512, 740) * 4 + $urandom_range(0, 3));
      len = $urandom_range(1, 20);
      run_copy(s, d, len, bit'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
